mipi_tx_frame_timing: RTL and testbench

- Generates the per-frame and per-line sync pulses (Vsync, Hsync) and the frame_start window on the MIPI TX clock.
- Its outputs feed directly into the downstream line-read timing stage, which counts lines and issues FIFO read enables.
- Paces active lines on a line-ready handshake from the pixel line buffer, so a line is never started before its data is buffered.
- Holds blanking-line cadence between frames.

---
 rtl/mipi_tx_frame_timing_if.sv | 22 ++
 rtl/mipi_tx_frame_timing.sv | 160 ++++++++++++++++
 tb/tb_mipi_tx_frame_timing.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mipi_tx_frame_timing_if.sv
// Sync/handshake bundle between the frame timing generator and its neighbours.
// master = timing generator (drives sync outputs), slave = line buffer / line-read side.
interface mipi_tx_frame_timing_if;
  logic        enable;
  logic        line_ready;
  logic        Vsync;
  logic        Hsync;
  logic        frame_start;
  logic [11:0] line_cnt;
  logic        frame_done;
  logic        underrun;

  modport master (
    input  enable, line_ready,
    output Vsync, Hsync, frame_start, line_cnt, frame_done, underrun
  );

  modport slave (
    output enable, line_ready,
    input  Vsync, Hsync, frame_start, line_cnt, frame_done, underrun
  );
endinterface

// File: rtl/mipi_tx_frame_timing.sv
// Frame/line sync generator on the TX byte clock; all outputs registered (1-cycle latency from state).
// Active lines wait on line_ready (WAIT_LINE is transparent when already ready); a multi-cycle stall flags underrun.
module mipi_tx_frame_timing #(
  parameter logic [11:0] H_TOTAL  = 12'd800,
  parameter logic [11:0] V_ACTIVE = 12'd2688,
  parameter logic [11:0] V_FP     = 12'd8,
  parameter logic [11:0] V_BP     = 12'd8
) (
  input  logic                          CLK_tx,
  input  logic                          RSTn,
  mipi_tx_frame_timing_if.master        tim
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    VS        = 3'd1,
    FP        = 3'd2,
    WAIT_LINE = 3'd3,
    ACT       = 3'd4,
    BP        = 3'd5
  } state_t;

  state_t      state;
  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic [11:0] line_cnt_q;
  logic        vsync_q;
  logic        hsync_q;
  logic        frame_start_q;
  logic        frame_done_q;
  logic        underrun_q;
  logic        line_end;

  assign line_end = (h_cnt == H_TOTAL - 12'd1);

  assign tim.Vsync       = vsync_q;
  assign tim.Hsync       = hsync_q;
  assign tim.frame_start = frame_start_q;
  assign tim.line_cnt    = line_cnt_q;
  assign tim.frame_done  = frame_done_q;
  assign tim.underrun    = underrun_q;

  always_ff @(posedge CLK_tx or negedge RSTn) begin
    if (!RSTn) begin
      state         <= IDLE;
      h_cnt         <= 12'd0;
      v_cnt         <= 12'd0;
      line_cnt_q    <= 12'd0;
      vsync_q       <= 1'b0;
      hsync_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      // Pulses default low; each branch raises the ones due in the next cycle.
      vsync_q      <= 1'b0;
      hsync_q      <= 1'b0;
      frame_done_q <= 1'b0;

      case (state)
        IDLE: begin
          if (tim.enable) begin
            state   <= VS;
            vsync_q <= 1'b1;
            h_cnt   <= 12'd0;
            v_cnt   <= 12'd0;
          end
        end

        VS: begin
          state   <= FP;
          hsync_q <= 1'b1;
          h_cnt   <= 12'd0;
          v_cnt   <= 12'd0;
        end

        FP: begin
          if (line_end) begin
            h_cnt <= 12'd0;
            if (v_cnt == V_FP - 12'd1) begin
              v_cnt <= 12'd0;
              if (tim.line_ready) begin
                state         <= ACT;
                hsync_q       <= 1'b1;
                frame_start_q <= 1'b1;
              end else begin
                state <= WAIT_LINE;
              end
            end else begin
              v_cnt   <= v_cnt + 12'd1;
              hsync_q <= 1'b1;
            end
          end else begin
            h_cnt <= h_cnt + 12'd1;
          end
        end

        WAIT_LINE: begin
          h_cnt <= 12'd0;
          if (tim.line_ready) begin
            state         <= ACT;
            hsync_q       <= 1'b1;
            frame_start_q <= 1'b1;
          end else begin
            // Still not ready: WAIT_LINE will be held for a second cycle.
            underrun_q <= 1'b1;
          end
        end

        ACT: begin
          if (line_end) begin
            h_cnt <= 12'd0;
            if (line_cnt_q == V_ACTIVE - 12'd1) begin
              line_cnt_q    <= 12'd0;
              frame_start_q <= 1'b0;
              state         <= BP;
              v_cnt         <= 12'd0;
              hsync_q       <= 1'b1;
            end else begin
              line_cnt_q <= line_cnt_q + 12'd1;
              if (tim.line_ready) begin
                hsync_q <= 1'b1;
              end else begin
                state <= WAIT_LINE;
              end
            end
          end else begin
            h_cnt <= h_cnt + 12'd1;
          end
        end

        BP: begin
          if (line_end) begin
            h_cnt <= 12'd0;
            if (v_cnt == V_BP - 12'd1) begin
              v_cnt        <= 12'd0;
              frame_done_q <= 1'b1;
              if (tim.enable) begin
                state   <= VS;
                vsync_q <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else begin
              v_cnt   <= v_cnt + 12'd1;
              hsync_q <= 1'b1;
            end
          end else begin
            h_cnt <= h_cnt + 12'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_tx_frame_timing.sv
// Directed bench for mipi_tx_frame_timing with small frame geometry (H=16, VA=4, FP=2, BP=2).
module tb_mipi_tx_frame_timing;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;

  mipi_tx_frame_timing_if tim();

  mipi_tx_frame_timing #(
    .H_TOTAL (12'd16),
    .V_ACTIVE(12'd4),
    .V_FP    (12'd2),
    .V_BP    (12'd2)
  ) dut (
    .CLK_tx(clk),
    .RSTn  (rst_n),
    .tim   (tim)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log, sampled mid-cycle.
  int hs_q[$];
  int lc_q[$];
  int vs_q[$];
  int fd_q[$];
  int fs_rise_q[$];
  int fs_cnt  = 0;
  int fs_hs   = 0;
  int both    = 0;
  logic fs_prev = 1'b0;

  always @(negedge clk) begin
    if (tim.Hsync) begin
      hs_q.push_back(cyc);
      lc_q.push_back(int'(tim.line_cnt));
      if (tim.frame_start) fs_hs++;
    end
    if (tim.Vsync) vs_q.push_back(cyc);
    if (tim.frame_done) fd_q.push_back(cyc);
    if (tim.frame_start) fs_cnt++;
    if (tim.frame_start && !fs_prev) fs_rise_q.push_back(cyc);
    fs_prev = tim.frame_start;
    if (tim.Vsync && tim.Hsync) both++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_vs(input int n, input int limit);
    int k;
    k = 0;
    while (vs_q.size() < n && k < limit) begin
      step(1);
      k++;
    end
    chk("vs_wait", vs_q.size(), n);
  endtask

  task automatic wait_fd(input int n, input int limit);
    int k;
    k = 0;
    while (fd_q.size() < n && k < limit) begin
      step(1);
      k++;
    end
    chk("fd_wait", fd_q.size(), n);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_vsync"}, tim.Vsync, 0);
    chk({tag, "_hsync"}, tim.Hsync, 0);
    chk({tag, "_fstart"}, tim.frame_start, 0);
    chk({tag, "_linecnt"}, tim.line_cnt, 0);
    chk({tag, "_fdone"}, tim.frame_done, 0);
    chk({tag, "_underrun"}, tim.underrun, 0);
  endtask

  int lc_exp[8] = '{0, 0, 0, 1, 2, 3, 0, 0};

  initial begin
    int b_hs, b_vs, b_fd, b_fr, b_fs, b_fh;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    tim.enable = 1'b0;
    tim.line_ready = 1'b1;

    // Reset state
    step(2);
    chk_outs_zero("rst");
    rst_n = 1'b1;
    step(2);
    chk("idle_vsync", tim.Vsync, 0);

    // Three back-to-back frames, enable dropped during ACT of the third
    b_hs = hs_q.size(); b_vs = vs_q.size(); b_fd = fd_q.size();
    b_fr = fs_rise_q.size(); b_fs = fs_cnt; b_fh = fs_hs;
    tim.enable = 1'b1;
    step(1);
    chk("vs_first", tim.Vsync, 1);
    chk("vs_no_hs", tim.Hsync, 0);
    step(1);
    chk("fp0_hsync", tim.Hsync, 1);
    chk("fp0_no_vs", tim.Vsync, 0);
    wait_vs(b_vs + 3, 600);
    step(50);
    tim.enable = 1'b0;
    wait_fd(b_fd + 3, 300);
    step(200);
    chk("p1_vs_count", vs_q.size() - b_vs, 3);
    chk("p1_hs_count", hs_q.size() - b_hs, 24);
    chk("p1_fd_count", fd_q.size() - b_fd, 3);
    if (vs_q.size() >= b_vs + 3 && hs_q.size() >= b_hs + 24 && fd_q.size() >= b_fd + 3
        && fs_rise_q.size() >= b_fr + 3) begin
      chk("vs_period_1", vs_q[b_vs+1] - vs_q[b_vs], 129);
      chk("vs_period_2", vs_q[b_vs+2] - vs_q[b_vs+1], 129);
      chk("vs_to_hs", hs_q[b_hs] - vs_q[b_vs], 1);
      chk("hs_across_vs", hs_q[b_hs+8] - hs_q[b_hs+7], 17);
      for (int f = 0; f < 3; f++) begin
        for (int k = 1; k < 8; k++)
          chk($sformatf("hs_gap_f%0d_l%0d", f, k),
              hs_q[b_hs+8*f+k] - hs_q[b_hs+8*f+k-1], 16);
        for (int k = 0; k < 8; k++)
          chk($sformatf("linecnt_f%0d_l%0d", f, k), lc_q[b_hs+8*f+k], lc_exp[k]);
        chk($sformatf("fd_time_f%0d", f), fd_q[b_fd+f] - vs_q[b_vs+f], 129);
        chk($sformatf("fs_rise_f%0d", f), fs_rise_q[b_fr+f], hs_q[b_hs+8*f+2]);
      end
    end
    chk("p1_fs_cycles", fs_cnt - b_fs, 192);
    chk("p1_fs_hsyncs", fs_hs - b_fh, 12);
    chk("p1_underrun", tim.underrun, 0);

    // Five-cycle line_ready stall before active line 2
    b_hs = hs_q.size(); b_vs = vs_q.size(); b_fd = fd_q.size();
    b_fs = fs_cnt; b_fh = fs_hs;
    tim.enable = 1'b1;
    step(65);
    tim.line_ready = 1'b0;
    step(3);
    chk("stall_linecnt", tim.line_cnt, 2);
    chk("stall_hsync", tim.Hsync, 0);
    chk("stall_fstart", tim.frame_start, 1);
    chk("stall_underrun", tim.underrun, 1);
    step(2);
    tim.line_ready = 1'b1;
    tim.enable = 1'b0;
    wait_fd(b_fd + 1, 300);
    step(20);
    chk("p2_vs_count", vs_q.size() - b_vs, 1);
    chk("p2_hs_count", hs_q.size() - b_hs, 8);
    if (hs_q.size() >= b_hs + 8 && vs_q.size() >= b_vs + 1 && fd_q.size() >= b_fd + 1) begin
      chk("p2_gap_l1", hs_q[b_hs+3] - hs_q[b_hs+2], 16);
      chk("p2_gap_stall", hs_q[b_hs+4] - hs_q[b_hs+3], 21);
      chk("p2_gap_l3", hs_q[b_hs+5] - hs_q[b_hs+4], 16);
      chk("p2_fd_time", fd_q[b_fd] - vs_q[b_vs], 134);
    end
    chk("p2_fs_cycles", fs_cnt - b_fs, 69);
    chk("p2_fs_hsyncs", fs_hs - b_fh, 4);
    chk("p2_underrun_sticky", tim.underrun, 1);

    // Asynchronous reset in the middle of active line 1
    tim.enable = 1'b1;
    step(55);
    chk("pre_rst_fstart", tim.frame_start, 1);
    chk("pre_rst_linecnt", tim.line_cnt, 1);
    #1 rst_n = 1'b0;
    #1 chk_outs_zero("async_rst");
    step(1);
    rst_n = 1'b1;
    b_hs = hs_q.size(); b_vs = vs_q.size(); b_fd = fd_q.size();
    b_fs = fs_cnt; b_fh = fs_hs;
    step(1);
    chk("post_rst_vsync", tim.Vsync, 1);
    step(1);
    chk("post_rst_hsync", tim.Hsync, 1);
    tim.enable = 1'b0;
    wait_fd(b_fd + 1, 300);
    step(20);
    chk("p3_vs_count", vs_q.size() - b_vs, 1);
    chk("p3_hs_count", hs_q.size() - b_hs, 8);
    chk("p3_fs_cycles", fs_cnt - b_fs, 64);
    chk("p3_fs_hsyncs", fs_hs - b_fh, 4);
    chk("p3_underrun", tim.underrun, 0);

    chk("vs_hs_overlap", both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
